memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline: consumes the EX->ME latched outputs, runs the data-memory
//  access over a req/ready handshake (variable latency), resolves branches, latches results to WB.
//  Provides bypass data and destination info to the hazard unit (HU). Raises a stall while a load/store is outstanding.
// PARAMETERS
//  DATA_W  32  data/address width of ALU result, store data, memory bus
//  ADDR_W  5   register-file address width
//  PC_W    32  program-counter width
// PORTS
//  clk            in   1       clock
//  reset          in   1       asynchronous, active-high reset
//  rf_we_i        in   1       from EX: instruction writes RF
//  mem_we_i       in   1       from EX: store
//  mem2rf_i       in   1       from EX: load (RF written from memory)
//  branch_i       in   1       from EX: conditional branch
//  check_eq_i     in   1       from EX: 1=taken if equal (ALU result zero), 0=taken if not equal
//  mem_wdata_i    in   DATA_W  from EX: store data
//  rf_waddr_i     in   ADDR_W  from EX: destination register
//  alu_result_i   in   DATA_W  from EX: ALU result / memory address
//  pc_branch_i    in   PC_W    from EX: branch target
//  latch_en       in   1       ME->WB latch advance enable (from HU)
//  latch_clear    in   1       ME->WB latch flush (from HU)
//  dmem_req_o     out  1       data-memory request
//  dmem_we_o      out  1       request is a write
//  dmem_addr_o    out  DATA_W  = alu_result_i
//  dmem_wdata_o   out  DATA_W  = mem_wdata_i
//  dmem_ready_i   in   1       completes request in the cycle it is high with dmem_req_o
//  dmem_rdata_i   in   DATA_W  read data, valid when dmem_ready_i high
//  pc_src_o       out  1       branch taken -> fetch redirect
//  pc_branch_o    out  PC_W    = pc_branch_i
//  stall_o        out  1       to HU: memory access not yet complete
//  rf_data_m_o    out  DATA_W  to EX bypass: alu_result_i
//  rf_dst_m_o     out  ADDR_W  to HU: rf_waddr_i;  rf_we_m_o out 1 to HU: rf_we_i
//  rf_we_o, mem2rf_o, rf_waddr_o, alu_result_o, mem_rdata_o   out  to WB (latched)
// BEHAVIOUR
//  - mem_op = mem_we_i | mem2rf_i. pc_src_o = branch_i & (check_eq_i ~^ (alu_result_i==0)); comb.
//  - FSM states IDLE, WAIT, DONE; reset -> IDLE.
//    IDLE: mem_op -> dmem_req_o=1. ready&latch_en -> stay IDLE; ready&!latch_en -> DONE (buffer rdata);
//          !ready -> WAIT.
//    WAIT: dmem_req_o=1, addr/we/wdata held stable by stall. ready&latch_en -> IDLE; ready&!latch_en -> DONE.
//    DONE: dmem_req_o=0 (no re-issue); rdata from buffer; latch_en -> IDLE.
//  - stall_o = mem_op & !dmem_ready_i & (state!=DONE). Zero-wait access: no stall cycle.
//  - mem_rdata to WB = (state==DONE) ? buffer : dmem_rdata_i.
//  - WB latches: posedge clk; latch_clear -> zero (priority); else latch_en -> load; else hold.
//    Latency 1 cycle ME->WB. HU must hold latch_en low while stall_o is high.
//  - latch_clear also returns FSM to IDLE and drops dmem_req_o next cycle (abandoned access).
//  - Reset (any state, incl. mid-access): all latched outputs 0, buffer 0, FSM IDLE, dmem_req_o 0
//    from reset assertion; memory must tolerate an abandoned request.
//  - Non-memory instructions: dmem_req_o=0, stall_o=0, FSM stays IDLE.
// STRUCTURE
//  - Shared package pipeline_pkg: mem_state_t enum {MEM_IDLE, MEM_WAIT, MEM_DONE}; width defaults.
//  - WB registers reuse existing `latch` sub-module (one instance per field); FSM + rdata buffer local.
// TESTING
//  - Zero-wait load: mem2rf=1, addr=0x10, ready same cycle, rdata=0xDEADBEEF -> stall_o never high,
//    mem_rdata_o=0xDEADBEEF, rf_waddr_o latched next edge.
//  - 3-cycle store: mem_we=1, wdata=0x55, ready on 3rd cycle -> req high 3 cycles, stall_o high 2, dmem_we_o=1.
//  - Load completes with latch_en=0 for 2 cycles -> FSM DONE, req low, rdata held; output on release.
//  - BEQ alu_result=0 check_eq=1 -> pc_src_o=1; alu_result=4 -> 0; BNE alu_result=4 -> 1.
//  - Reset asserted during WAIT -> req drops immediately, all outputs 0, next load behaves normally.
//  - latch_clear with latch_en=1 during WAIT -> WB fields 0, FSM IDLE next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Types and width defaults shared by the pipeline stages.
package pipeline_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_PC_W   = 32;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;
endpackage

// File: rtl/latch.sv
// Pipeline register with flush (priority) and advance enable.
module latch #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      q <= '0;
        else if (clear) q <= '0;
        else if (en)    q <= d;
    end
endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory access FSM, branch resolution, ME->WB pipeline registers.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PC_W   = DEF_PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rf_we_i,
    input  logic              mem_we_i,
    input  logic              mem2rf_i,
    input  logic              branch_i,
    input  logic              check_eq_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [ADDR_W-1:0] rf_waddr_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [PC_W-1:0]   pc_branch_i,
    input  logic              latch_en,
    input  logic              latch_clear,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ready_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              pc_src_o,
    output logic [PC_W-1:0]   pc_branch_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] rf_data_m_o,
    output logic [ADDR_W-1:0] rf_dst_m_o,
    output logic              rf_we_m_o,
    output logic              rf_we_o,
    output logic              mem2rf_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output mem_state_t        mem_state_o
);
    // Handshake: a transfer completes in any cycle where dmem_req_o and dmem_ready_i are
    // both high; address/we/wdata stay stable until then because the stall freezes EX.
    mem_state_t        state, state_next;
    logic              mem_op;
    logic              req;
    logic [DATA_W-1:0] rdata_buf;
    logic [DATA_W-1:0] rdata_sel;

    assign mem_op       = mem_we_i | mem2rf_i;
    assign pc_src_o     = branch_i & (check_eq_i ~^ (alu_result_i == '0));
    assign pc_branch_o  = pc_branch_i;
    assign dmem_we_o    = mem_we_i;
    assign dmem_addr_o  = alu_result_i;
    assign dmem_wdata_o = mem_wdata_i;
    assign rf_data_m_o  = alu_result_i;
    assign rf_dst_m_o   = rf_waddr_i;
    assign rf_we_m_o    = rf_we_i;
    assign mem_state_o  = state;

    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (mem_op) begin
                    req = 1'b1;
                    if (dmem_ready_i) state_next = latch_en ? MEM_IDLE : MEM_DONE;
                    else              state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                req = 1'b1;
                if (dmem_ready_i) state_next = latch_en ? MEM_IDLE : MEM_DONE;
            end
            MEM_DONE: begin
                if (latch_en) state_next = MEM_IDLE;
            end
            default: state_next = MEM_IDLE;
        endcase
        if (latch_clear) state_next = MEM_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MEM_IDLE;
        else       state <= state_next;
    end

    // Read data completed while WB is blocked is parked here so the request is not re-issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata_buf <= '0;
        else if (req && dmem_ready_i && !latch_en)
            rdata_buf <= dmem_rdata_i;
    end

    assign dmem_req_o = req & ~reset;
    assign stall_o    = mem_op & ~dmem_ready_i & (state != MEM_DONE);
    assign rdata_sel  = (state == MEM_DONE) ? rdata_buf : dmem_rdata_i;

    latch #(.W(1)) u_rf_we (
        .clk(clk), .reset(reset), .en(latch_en), .clear(latch_clear), .d(rf_we_i), .q(rf_we_o));
    latch #(.W(1)) u_mem2rf (
        .clk(clk), .reset(reset), .en(latch_en), .clear(latch_clear), .d(mem2rf_i), .q(mem2rf_o));
    latch #(.W(ADDR_W)) u_rf_waddr (
        .clk(clk), .reset(reset), .en(latch_en), .clear(latch_clear), .d(rf_waddr_i), .q(rf_waddr_o));
    latch #(.W(DATA_W)) u_alu_result (
        .clk(clk), .reset(reset), .en(latch_en), .clear(latch_clear), .d(alu_result_i),
        .q(alu_result_o));
    latch #(.W(DATA_W)) u_mem_rdata (
        .clk(clk), .reset(reset), .en(latch_en), .clear(latch_clear), .d(rdata_sel),
        .q(mem_rdata_o));
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: branch vector table, directed access sequences,
// and randomized instruction stream against a transaction-level model.
module tb_memory_stage;
    import pipeline_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i;
    logic [DW-1:0] mem_wdata_i, alu_result_i, dmem_rdata_i;
    logic [AW-1:0] rf_waddr_i;
    logic [PW-1:0] pc_branch_i;
    logic          latch_en, latch_clear, dmem_ready_i;
    logic          dmem_req_o, dmem_we_o, pc_src_o, stall_o, rf_we_m_o, rf_we_o, mem2rf_o;
    logic [DW-1:0] dmem_addr_o, dmem_wdata_o, rf_data_m_o, alu_result_o, mem_rdata_o;
    logic [PW-1:0] pc_branch_o;
    logic [AW-1:0] rf_dst_m_o, rf_waddr_o;
    mem_state_t    mem_state_o;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    memory_stage dut (
        .clk(clk), .reset(reset), .rf_we_i(rf_we_i), .mem_we_i(mem_we_i), .mem2rf_i(mem2rf_i),
        .branch_i(branch_i), .check_eq_i(check_eq_i), .mem_wdata_i(mem_wdata_i),
        .rf_waddr_i(rf_waddr_i), .alu_result_i(alu_result_i), .pc_branch_i(pc_branch_i),
        .latch_en(latch_en), .latch_clear(latch_clear), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i), .pc_src_o(pc_src_o),
        .pc_branch_o(pc_branch_o), .stall_o(stall_o), .rf_data_m_o(rf_data_m_o),
        .rf_dst_m_o(rf_dst_m_o), .rf_we_m_o(rf_we_m_o), .rf_we_o(rf_we_o), .mem2rf_o(mem2rf_o),
        .rf_waddr_o(rf_waddr_o), .alu_result_o(alu_result_o), .mem_rdata_o(mem_rdata_o),
        .mem_state_o(mem_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        rf_we_i = 0; mem_we_i = 0; mem2rf_i = 0; branch_i = 0; check_eq_i = 0;
        mem_wdata_i = '0; rf_waddr_i = '0; alu_result_i = '0; pc_branch_i = '0;
        latch_en = 1; latch_clear = 0; dmem_ready_i = 0; dmem_rdata_i = '0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic we, input logic [AW-1:0] wa,
                            input logic [DW-1:0] addr, input logic [DW-1:0] wd);
        mem2rf_i = ld; mem_we_i = st; rf_we_i = we; rf_waddr_i = wa;
        alu_result_i = addr; mem_wdata_i = wd; branch_i = 0;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic ld, input logic [AW-1:0] wa,
                            input logic [DW-1:0] alu, input logic [DW-1:0] rd);
        check({tag, ".rf_we"}, 64'(rf_we_o), 64'(we));
        check({tag, ".mem2rf"}, 64'(mem2rf_o), 64'(ld));
        check({tag, ".rf_waddr"}, 64'(rf_waddr_o), 64'(wa));
        check({tag, ".alu_result"}, 64'(alu_result_o), 64'(alu));
        check({tag, ".mem_rdata"}, 64'(mem_rdata_o), 64'(rd));
    endtask

    typedef struct {
        logic          branch;
        logic          check_eq;
        logic [DW-1:0] alu;
        logic          exp_pc_src;
    } br_vec_t;

    br_vec_t vecs[7];

    initial begin
        int req_cnt;
        int stall_cnt;
        vecs[0] = '{1'b1, 1'b1, 32'd0,          1'b1};  // BEQ equal
        vecs[1] = '{1'b1, 1'b1, 32'd4,          1'b0};  // BEQ not equal
        vecs[2] = '{1'b1, 1'b0, 32'd4,          1'b1};  // BNE not equal
        vecs[3] = '{1'b1, 1'b0, 32'd0,          1'b0};  // BNE equal
        vecs[4] = '{1'b0, 1'b1, 32'd0,          1'b0};  // not a branch
        vecs[5] = '{1'b1, 1'b1, 32'h8000_0000,  1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0001,  1'b1};

        drive_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_wb("reset", 0, 0, 0, 0, 0);
        check("reset.state", 64'(mem_state_o), 64'(MEM_IDLE));
        check("reset.req", 64'(dmem_req_o), 0);
        reset = 0;
        tick();

        // branch table plus pass-through paths
        for (int i = 0; i < 7; i++) begin
            branch_i = vecs[i].branch; check_eq_i = vecs[i].check_eq;
            alu_result_i = vecs[i].alu; pc_branch_i = $urandom;
            rf_waddr_i = AW'($urandom); rf_we_i = 1'($urandom); mem_wdata_i = $urandom;
            #1;
            check($sformatf("br%0d.pc_src", i), 64'(pc_src_o), 64'(vecs[i].exp_pc_src));
            check($sformatf("br%0d.pc_branch", i), 64'(pc_branch_o), 64'(pc_branch_i));
            check($sformatf("br%0d.bypass", i), {rf_data_m_o, 27'd0, rf_dst_m_o},
                  {alu_result_i, 27'd0, rf_waddr_i});
            check($sformatf("br%0d.rf_we_m", i), 64'(rf_we_m_o), 64'(rf_we_i));
            check($sformatf("br%0d.req", i), {62'd0, dmem_req_o, stall_o}, 0);
            tick();
        end
        drive_idle();
        tick();

        // zero-wait load
        drive_op(1, 0, 1, 5'd7, 32'h10, 32'h0);
        dmem_ready_i = 1; dmem_rdata_i = 32'hDEAD_BEEF; latch_en = 1;
        #1;
        check("zw.req", 64'(dmem_req_o), 1);
        check("zw.we", 64'(dmem_we_o), 0);
        check("zw.addr", 64'(dmem_addr_o), 64'h10);
        check("zw.stall", 64'(stall_o), 0);
        tick();
        check_wb("zw", 1, 1, 5'd7, 32'h10, 32'hDEAD_BEEF);
        check("zw.state", 64'(mem_state_o), 64'(MEM_IDLE));

        // 3-cycle store
        drive_op(0, 1, 0, 5'd9, 32'h20, 32'h55);
        dmem_ready_i = 0; latch_en = 0; dmem_rdata_i = '0;
        req_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin dmem_ready_i = 1; latch_en = 1; end
            #1;
            req_cnt += int'(dmem_req_o);
            stall_cnt += int'(stall_o);
            check($sformatf("st%0d.we_wdata", c), {dmem_we_o, 31'd0, dmem_wdata_o}, {1'b1, 31'd0, 32'h55});
            tick();
            if (c == 0) check("st.state_wait", 64'(mem_state_o), 64'(MEM_WAIT));
        end
        check("st.req_cycles", 64'(req_cnt), 3);
        check("st.stall_cycles", 64'(stall_cnt), 2);
        check("st.state_idle", 64'(mem_state_o), 64'(MEM_IDLE));
        check("st.wb_alu", 64'(alu_result_o), 64'h20);

        // load completes while WB is blocked for two cycles
        drive_op(1, 0, 1, 5'd3, 32'h30, 32'h0);
        dmem_ready_i = 1; dmem_rdata_i = 32'h1234_5678; latch_en = 0;
        #1;
        check("hold.stall", 64'(stall_o), 0);
        tick();
        check("hold.state_done", 64'(mem_state_o), 64'(MEM_DONE));
        dmem_ready_i = 0; dmem_rdata_i = 32'h0BAD_0BAD;
        #1;
        check("hold.req_low", {62'd0, dmem_req_o, stall_o}, 0);
        check("hold.wb_held", 64'(rf_waddr_o), 64'd9);
        tick();
        check("hold.state_done2", 64'(mem_state_o), 64'(MEM_DONE));
        latch_en = 1;
        #1;
        check("hold.req_low2", 64'(dmem_req_o), 0);
        tick();
        check_wb("hold", 1, 1, 5'd3, 32'h30, 32'h1234_5678);
        check("hold.state_idle", 64'(mem_state_o), 64'(MEM_IDLE));

        // reset during WAIT
        drive_op(1, 0, 1, 5'd12, 32'h40, 32'h0);
        dmem_ready_i = 0; latch_en = 0;
        tick();
        check("rst.state_wait", 64'(mem_state_o), 64'(MEM_WAIT));
        reset = 1;
        #1;
        check("rst.req_drop", 64'(dmem_req_o), 0);
        check("rst.state", 64'(mem_state_o), 64'(MEM_IDLE));
        check_wb("rst", 0, 0, 0, 0, 0);
        tick();
        reset = 0;
        drive_op(1, 0, 1, 5'd13, 32'h44, 32'h0);
        dmem_ready_i = 1; dmem_rdata_i = 32'hCAFE_F00D; latch_en = 1;
        #1;
        check("rst.next_req", {62'd0, dmem_req_o, stall_o}, 64'b10);
        tick();
        check_wb("rst_next", 1, 1, 5'd13, 32'h44, 32'hCAFE_F00D);

        // latch_clear during WAIT
        drive_op(1, 0, 1, 5'd14, 32'h48, 32'h0);
        dmem_ready_i = 0; latch_en = 0;
        tick();
        check("clr.state_wait", 64'(mem_state_o), 64'(MEM_WAIT));
        latch_clear = 1; latch_en = 1;
        tick();
        check_wb("clr", 0, 0, 0, 0, 0);
        check("clr.state", 64'(mem_state_o), 64'(MEM_IDLE));
        drive_idle();
        #1;
        check("clr.req_drop", 64'(dmem_req_o), 0);
        tick();

        // randomized instruction stream against a transaction-level model
        for (int n = 0; n < 60; n++) begin
            int            kind, lat, hold;
            logic          ld, st, we;
            logic [AW-1:0] wa;
            logic [DW-1:0] addr, data, exp_rd;
            kind = $urandom_range(0, 2);
            ld = (kind == 1); st = (kind == 2);
            we = 1'($urandom); wa = AW'($urandom); addr = $urandom; data = $urandom;
            lat = (kind != 0) ? $urandom_range(0, 3) : 0;
            hold = $urandom_range(0, 2);
            drive_op(ld, st, we, wa, addr, $urandom);
            branch_i = 1'($urandom); check_eq_i = 1'($urandom);
            latch_clear = 0;
            if (kind != 0) exp_q.push_back(data);
            exp_rd = '0;
            for (int c = 0; c < lat; c++) begin
                dmem_ready_i = 0; latch_en = 0; dmem_rdata_i = $urandom;
                #1;
                check($sformatf("rnd%0d.wait", n), {62'd0, dmem_req_o, stall_o}, 64'b11);
                tick();
            end
            dmem_ready_i = (kind != 0) ? 1'b1 : 1'($urandom);
            dmem_rdata_i = (kind != 0) ? data : $urandom;
            latch_en = (hold == 0);
            #1;
            check($sformatf("rnd%0d.done", n), {62'd0, dmem_req_o, stall_o}, {62'd0, kind != 0, 1'b0});
            check($sformatf("rnd%0d.pc_src", n), 64'(pc_src_o),
                  64'(branch_i && (check_eq_i ? (addr == 0) : (addr != 0))));
            if (hold == 0) exp_rd = (kind != 0) ? exp_q.pop_front() : dmem_rdata_i;
            tick();
            if (hold > 0) begin
                for (int h = 0; h < hold; h++) begin
                    dmem_ready_i = 0; dmem_rdata_i = $urandom; latch_en = (h == hold - 1);
                    #1;
                    check($sformatf("rnd%0d.hold", n), {62'd0, dmem_req_o, stall_o}, 0);
                    if (h == hold - 1) exp_rd = (kind != 0) ? exp_q.pop_front() : dmem_rdata_i;
                    tick();
                end
            end
            check_wb($sformatf("rnd%0d", n), we, ld, wa, addr, exp_rd);
            check($sformatf("rnd%0d.state", n), 64'(mem_state_o), 64'(MEM_IDLE));
        end

        check("exp_q.empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
